// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter and sequencer for the shared 8-bit ALU
module alu_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [3:0]       req0_op,
    input  logic [3:0]       req1_op,
    input  logic [7:0]       req0_a,
    input  logic [7:0]       req0_b,
    input  logic [7:0]       req1_a,
    input  logic [7:0]       req1_b,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [7:0]       rsp_result,
    output logic [3:0]       rsp_nzvc,
    output logic             rsp_err,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_result,
    input  logic [3:0]       alu_nzvc,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NREQ-1:0] valid_vec;
    logic            last;
    logic            owner;
    logic            bad_op;
    logic            grant;
    logic            accept;
    logic            rsp_hs;
    logic            div_zero;
    logic            illegal_in;
    logic [3:0]      sel_in;
    logic [7:0]      a_in;
    logic [7:0]      b_in;

    assign valid_vec = {req1_valid, req0_valid};

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        grant      = valid_vec[1] & (~valid_vec[0] | ~last);
        sel_in     = grant ? req1_op : req0_op;
        a_in       = grant ? req1_a : req0_a;
        b_in       = grant ? req1_b : req0_b;
        illegal_in = (sel_in >= 4'd10);
        div_zero   = ((alu_sel == 4'd3) || (alu_sel == 4'd4)) && (alu_b == 8'h00);
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        rsp_hs     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                accept     = |valid_vec;
                req0_ready = accept & ~grant;
                req1_ready = accept & grant;
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner;
                rsp1_valid = owner;
                rsp_hs     = owner ? rsp1_ready : rsp0_ready;
                if (rsp_hs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            bad_op     <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_sel    <= 4'h0;
            rsp_result <= 8'h00;
            rsp_nzvc   <= 4'h0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= grant;
                last  <= grant;
                // Illegal opcodes run a harmless 0+0 so the ALU never sees undefined selects.
                if (illegal_in) begin
                    alu_sel <= 4'h0;
                    alu_a   <= 8'h00;
                    alu_b   <= 8'h00;
                    bad_op  <= 1'b1;
                end else begin
                    alu_sel <= sel_in;
                    alu_a   <= a_in;
                    alu_b   <= b_in;
                end
            end
            if (state == EXEC) begin
                rsp_err <= bad_op | div_zero;
                if (bad_op) begin
                    rsp_result <= 8'h00;
                    rsp_nzvc   <= 4'h0;
                end else begin
                    rsp_result <= alu_result;
                    rsp_nzvc   <= alu_nzvc;
                end
            end
            if (rsp_hs) begin
                op_count <= op_count + CNT_W'(1);
                bad_op   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_op = 4'h0, req1_op = 4'h0;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp_result;
    logic [3:0] rsp_nzvc;
    logic       rsp_err;
    logic [7:0] alu_a, alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_result;
    logic [3:0] alu_nzvc;
    logic       busy;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_nzvc(rsp_nzvc), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_nzvc(alu_nzvc),
        .busy(busy), .op_count(op_count)
    );

    // Reference ALU: returns {N,Z,V,C,result}.
    function automatic logic [11:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  t;
        logic [15:0] p;
        logic [7:0]  r;
        logic        v, c;
        v = 1'b0; c = 1'b0; r = 8'h00;
        case (s)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: begin p = a * b; r = p[7:0]; end
            4'd3: begin if (b == 8'h00) return 12'hFFF; r = a / b; end
            4'd4: begin if (b == 8'h00) return 12'hFFF; r = a % b; end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd9: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: return 12'h000;
        endcase
        return {r[7], (r == 8'h00), v, c, r};
    endfunction

    assign {alu_nzvc, alu_result} = alu_f(alu_sel, alu_a, alu_b);

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } req_t;

    req_t q0[$];
    req_t q1[$];
    int   order[$];
    int   total = 0;
    int   bad = 0;

    // Transaction-level model: one op in flight, aged in cycles since acceptance.
    bit         m_have = 0;
    int         m_age = 0;
    bit         m_owner = 0;
    bit         m_last = 1;
    logic [7:0] m_a = 0, m_b = 0, m_res = 0, m_cnt = 0;
    logic [3:0] m_sel = 0, m_nzvc = 0;
    bit         m_err = 0;
    logic [11:0] p_out;
    bit         p_err;
    bit         m_acc0 = 0, m_acc1 = 0;

    function automatic int grant_of(input logic v0, input logic v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function void model_update();
        int         g;
        logic [3:0] op;
        logic [7:0] a, b;
        m_acc0 = 0;
        m_acc1 = 0;
        if (!rst_n) begin
            m_have = 0; m_age = 0; m_last = 1; m_owner = 0;
            m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_nzvc = 0; m_err = 0; m_cnt = 0;
        end else if (!m_have) begin
            g = grant_of(req0_valid, req1_valid, m_last);
            if (g >= 0) begin
                op = (g == 1) ? req1_op : req0_op;
                a  = (g == 1) ? req1_a : req0_a;
                b  = (g == 1) ? req1_b : req0_b;
                if (op >= 4'd10) begin
                    m_sel = 0; m_a = 0; m_b = 0; p_out = 12'h000; p_err = 1;
                end else begin
                    m_sel = op; m_a = a; m_b = b;
                    p_out = alu_f(op, a, b);
                    p_err = ((op == 4'd3) || (op == 4'd4)) && (b == 8'h00);
                end
                m_have = 1; m_age = 1; m_owner = g[0]; m_last = g[0];
                if (g == 0) m_acc0 = 1; else m_acc1 = 1;
            end
        end else if (m_age == 1) begin
            {m_nzvc, m_res} = p_out;
            m_err = p_err;
            m_age = 2;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_cnt = m_cnt + 8'd1;
            m_have = 0;
        end
    endfunction

    task automatic drive();
        req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
    endtask

    task automatic cmp_now();
        int g;
        bit rv;
        #1;
        g  = m_have ? -1 : grant_of(req0_valid, req1_valid, m_last);
        rv = m_have && (m_age >= 2);
        chk("busy", busy, m_have);
        chk("req0_ready", req0_ready, g == 0);
        chk("req1_ready", req1_ready, g == 1);
        chk("rsp0_valid", rsp0_valid, rv && !m_owner);
        chk("rsp1_valid", rsp1_valid, rv && m_owner);
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_nzvc", rsp_nzvc, m_nzvc);
        chk("rsp_err", rsp_err, m_err);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        chk("alu_sel", alu_sel, m_sel);
        chk("op_count", op_count, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
        if (m_acc0) void'(q0.pop_front());
        if (m_acc1) void'(q1.pop_front());
    endtask

    task automatic cycle();
        drive();
        cmp_now();
        advance();
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        rst_n = 1'b0;
        drive();
        advance();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic wait_resp(input string name);
        for (int i = 0; i < 20; i++) begin
            drive();
            cmp_now();
            if (m_have && m_age >= 2) return;
            advance();
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (!m_have && q0.size() == 0 && q1.size() == 0) return;
            cycle();
        end
        chk("drain_timeout", 0, 1);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        r.a  = 8'($urandom);
        r.b  = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
        return r;
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        drive();
        cmp_now();
        chk("reset_busy", busy, 0);
        chk("reset_alu_sel", alu_sel, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_op_count", op_count, 0);

        // Add 0x7F + 0x01 from requester 0.
        rsp0_ready = 1'b1;
        q0.push_back('{4'h0, 8'h7F, 8'h01});
        drive(); cmp_now();
        chk("t1_req0_ready_c0", req0_ready, 1);
        advance();
        cycle();
        drive(); cmp_now();
        chk("t1_rsp0_valid_c2", rsp0_valid, 1);
        chk("t1_result", rsp_result, 8'h80);
        chk("t1_nzvc", rsp_nzvc, 4'hA);
        chk("t1_err", rsp_err, 0);
        advance();
        drive(); cmp_now();
        chk("t1_op_count", op_count, 1);
        advance();

        // Both requesters contend continuously.
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{4'h6, 8'(8'h10 + i), 8'(8'h01 << i)});
            q1.push_back('{4'h6, 8'(8'h80 + i), 8'(8'h20 + i)});
        end
        for (int i = 0; i < 60; i++) begin
            if (!m_have && q0.size() == 0 && q1.size() == 0) break;
            drive(); cmp_now();
            if (req0_valid && req0_ready) order.push_back(0);
            if (req1_valid && req1_ready) order.push_back(1);
            advance();
        end
        chk("rr_grants", order.size(), 8);
        for (int i = 0; i < order.size(); i++) chk("rr_order", order[i], i % 2);
        drive(); cmp_now();
        chk("rr_op_count", op_count, 8);

        // Divide and modulo by zero from requester 1.
        q1.push_back('{4'h3, 8'h10, 8'h00});
        wait_resp("div0");
        chk("div0_rsp1_valid", rsp1_valid, 1);
        chk("div0_result", rsp_result, 8'hFF);
        chk("div0_nzvc", rsp_nzvc, 4'hF);
        chk("div0_err", rsp_err, 1);
        advance();
        q1.push_back('{4'h4, 8'h10, 8'h00});
        wait_resp("mod0");
        chk("mod0_result", rsp_result, 8'hFF);
        chk("mod0_nzvc", rsp_nzvc, 4'hF);
        chk("mod0_err", rsp_err, 1);
        advance();

        // Illegal opcode.
        q0.push_back('{4'hC, 8'h55, 8'hAA});
        wait_resp("illegal");
        chk("ill_alu_sel", alu_sel, 0);
        chk("ill_alu_a", alu_a, 0);
        chk("ill_alu_b", alu_b, 0);
        chk("ill_result", rsp_result, 0);
        chk("ill_nzvc", rsp_nzvc, 0);
        chk("ill_err", rsp_err, 1);
        advance();

        // Response backpressure with requester 1 waiting.
        rsp0_ready = 1'b0;
        q0.push_back('{4'h1, 8'h30, 8'h10});
        wait_resp("bp");
        advance();
        q1.push_back('{4'h7, 8'h0F, 8'hF0});
        for (int i = 0; i < 5; i++) begin
            drive(); cmp_now();
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_result", rsp_result, 8'h20);
            chk("bp_nzvc", rsp_nzvc, 4'h0);
            chk("bp_req1_ready", req1_ready, 0);
            advance();
        end
        rsp0_ready = 1'b1;
        drive(); cmp_now();
        chk("bp_hs_req1_ready", req1_ready, 0);
        advance();
        drive(); cmp_now();
        chk("bp_req1_accept", req1_ready, 1);
        advance();
        drain();

        // Reset while an op is executing.
        do_reset();
        q0.push_back('{4'h0, 8'h7F, 8'h01});
        cycle();
        drive(); cmp_now();
        chk("rx_busy_exec", busy, 1);
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
        drive(); cmp_now();
        chk("rx_busy", busy, 0);
        chk("rx_rsp0_valid", rsp0_valid, 0);
        chk("rx_op_count", op_count, 0);
        chk("rx_alu_a", alu_a, 0);
        chk("rx_result", rsp_result, 0);
        advance();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
            if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cycle();
            rst_n = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (opcode plus two operands) from two independent clients with a valid/ready handshake and grants them round-robin. It drives the ALU from registered operands, captures `Result`/`NZVC` one cycle later, and returns them to the winning client on a held response channel. It sits between the instruction-execute path (requester 0) and the auxiliary/debug path (requester 1) and the combinational ALU.

## Interface
Parameters:
- `NREQ`, 2: number of requesters. Fixed at 2; the pointer logic is written for two.
- `CNT_W`, 8: width of the completed-operation counter.

Ports:
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_op`, `req1_op`  in  4  ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  8  operands.
- `rsp0_valid`, `rsp1_valid`  out  1  response held for the requester.
- `rsp0_ready`, `rsp1_ready`  in  1  response consumed.
- `rsp_result`  out  8  captured result, shared by both response channels.
- `rsp_nzvc`  out  4  captured flags N,Z,V,C (bit 3 to bit 0).
- `rsp_err`  out  1  illegal opcode, or divide/modulo by zero.
- `alu_a`, `alu_b`  out  8  registered operands to the ALU.
- `alu_sel`  out  4  registered opcode to the ALU.
- `alu_result`  in  8  ALU `Result`.
- `alu_nzvc`  in  4  ALU `NZVC`.
- `busy`  out  1  high when the FSM is not in IDLE.
- `op_count`  out  CNT_W  number of completed response handshakes, wrapping.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is `g`. If exactly one `reqN_valid` is high, `g` is that requester. If both are high, `g` is the requester other than `last`.
  - `reqg_ready` is asserted combinationally in the same cycle. The non-granted ready stays 0.
  - On the accept edge: latch `op`, `a`, `b` and `g` into `alu_sel`/`alu_a`/`alu_b`/`owner`; set `last` to `g`; go to EXEC.
- Illegal opcode (4'b1010 to 4'b1111):
  - Latched as `alu_sel` = 0000 and `alu_a` = `alu_b` = 0.
  - An internal `bad_op` flag is set.
- EXEC, one cycle:
  - Capture `rsp_result` and `rsp_nzvc` from `alu_result`/`alu_nzvc`; go to RESP.
  - `rsp_err` = `bad_op` OR (`alu_sel` ∈ {0011, 0100} AND `alu_b` == 0).
  - If `bad_op`: force `rsp_result` = 00 and `rsp_nzvc` = 0000.
  - Divide/modulo by zero passes the ALU's FF / 1111 through unchanged, with `rsp_err` = 1.
- RESP:
  - `rsp<owner>_valid` = 1. The other `rspN_valid` = 0.
  - `rsp_result`, `rsp_nzvc` and `rsp_err` stay stable until the handshake.
  - On `rsp<owner>_valid` and `rsp<owner>_ready`: increment `op_count` (wraps FF to 00), clear `bad_op`, go to IDLE.
- Both `reqN_ready` are 0 in EXEC and RESP. Requests arriving then wait; their valid must stay high and their payload stable.
- `alu_a`, `alu_b` and `alu_sel` hold their last value in IDLE and RESP.

## Timing
- Reset (`rst_n` low at an edge), from any state:
  - state = IDLE; `last` = 1, so requester 0 wins first.
  - `alu_a` = `alu_b` = 00, `alu_sel` = 0000.
  - `rsp_result` = 00, `rsp_nzvc` = 0000, `rsp_err` = 0.
  - `rspN_valid` = 0, `busy` = 0, `op_count` = 0.
- Reset mid-operation discards the in-flight op. No response is produced and `op_count` is unchanged from 0.
- Latency: accept at edge T (IDLE); EXEC during T+1; `rsp_valid` high from T+2.
- A response with `rsp_ready` already high completes at edge T+2. FSM is in IDLE during T+3, so the next accept is possible at the end of T+3. Peak throughput: one op per 3 cycles.
- `rsp_ready` while `rsp_valid` is low is ignored.
- Both requesters valid continuously: grants strictly alternate 0, 1, 0, 1, …
- A lone requester is granted back-to-back, even if it was `last`.

## Test plan
- Reset, then `req0` op 0000, a = 0x7F, b = 0x01, `rsp0_ready` = 1:
  - `req0_ready` high in cycle 0.
  - `rsp0_valid` high at cycle 2 with result 0x80, nzvc 1010, err 0.
  - `op_count` = 1.
- Both valid continuously, 4 ops each, op 0110, distinct operands:
  - Grant order 0,1,0,1,…
  - Each response routed to the correct `rspN_valid`.
  - `op_count` = 8.
- `req1` op 0011, a = 0x10, b = 0x00:
  - result 0xFF, nzvc 1111, err 1.
  - Repeat with op 0100: same response.
- `req0` op 1100 (illegal), a = 0x55, b = 0xAA:
  - `alu_sel` = 0000, `alu_a` = `alu_b` = 00.
  - result 00, nzvc 0000, err 1.
- Backpressure: hold `rsp0_ready` = 0 for 5 cycles while `req1_valid` = 1:
  - response stays stable.
  - `req1_ready` stays 0 throughout.
  - `req1` is accepted on the first IDLE cycle after the handshake.
- Assert `rst_n` = 0 during EXEC:
  - next cycle IDLE, no `rsp_valid`, `op_count` 0.
  - All outputs at reset values.
